// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: aligns and checks EX/MEM accesses, drives a req/gnt/rvalid
// data port, stalls the pipeline while an access is outstanding, and registers MEM/WB.
module mem_stage_lsu #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] reg_data2_in,
    input  logic [4:0]  rd_in,
    input  logic [2:0]  func3_in,
    input  logic [1:0]  wb_sel_in,
    input  logic [31:0] pc_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        reg_write_in,
    input  logic        mem_to_reg_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic        wb_mem_to_reg,
    output logic [4:0]  wb_rd,
    output logic [1:0]  wb_sel,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_load_data,
    output logic        mem_fault,
    output logic [1:0]  mem_fault_cause
);

    typedef enum logic [1:0] {StIdle, StReq, StWaitR} state_e;

    localparam logic [7:0] LastWait = 8'(MAX_WAIT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        access, illegal, misaligned, legal, timeout;
    logic        req, done, load_ok;
    logic [1:0]  cause;
    logic [31:0] st_wdata, ld_ext;
    logic [3:0]  st_be;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign access = ex_valid & (mem_read_in | mem_write_in);

    // Legal loads: 000,001,010,100,101. Legal stores: 000,001,010.
    always_comb begin
        illegal = 1'b0;
        if (mem_read_in && mem_write_in) begin
            illegal = 1'b1;
        end else if (mem_read_in) begin
            illegal = (&func3_in[1:0]) | (&func3_in[2:1]);
        end else if (mem_write_in) begin
            illegal = func3_in[2] | (&func3_in[1:0]);
        end
    end

    assign misaligned = ((func3_in[1:0] == 2'b01) & alu_result_in[0]) |
                        ((func3_in[1:0] == 2'b10) & (|alu_result_in[1:0]));
    assign legal      = access & ~illegal & ~misaligned;
    assign timeout    = (cnt_q == LastWait);

    always_comb begin
        unique case (func3_in[1:0])
            2'b00: begin
                st_wdata = {4{reg_data2_in[7:0]}};
                st_be    = 4'b0001 << alu_result_in[1:0];
            end
            2'b01: begin
                st_wdata = {2{reg_data2_in[15:0]}};
                st_be    = alu_result_in[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = reg_data2_in;
                st_be    = 4'b1111;
            end
        endcase
    end

    assign ld_byte = dmem_rdata[8*alu_result_in[1:0] +: 8];
    assign ld_half = alu_result_in[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        unique case (func3_in)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        done    = 1'b0;
        load_ok = 1'b0;
        cause   = 2'b00;
        unique case (state_q)
            StIdle: begin
                cnt_d = 8'd0;
                if (!access) begin
                    done = 1'b1;
                end else if (illegal) begin
                    done  = 1'b1;
                    cause = 2'b11;
                end else if (misaligned) begin
                    done  = 1'b1;
                    cause = 2'b01;
                end else begin
                    req = 1'b1;
                    if (dmem_gnt) begin
                        if (mem_write_in) done = 1'b1;
                        else state_d = StWaitR;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                cnt_d = cnt_q + 8'd1;
                // The last pending cycle drops the request so a late grant cannot be lost.
                if (timeout) begin
                    done    = 1'b1;
                    cause   = 2'b10;
                    state_d = StIdle;
                end else begin
                    req = 1'b1;
                    if (dmem_gnt) begin
                        if (mem_write_in) begin
                            done    = 1'b1;
                            state_d = StIdle;
                        end else begin
                            state_d = StWaitR;
                        end
                    end
                end
            end
            StWaitR: begin
                cnt_d = cnt_q + 8'd1;
                if (dmem_rvalid) begin
                    done    = 1'b1;
                    load_ok = 1'b1;
                    state_d = StIdle;
                end else if (timeout) begin
                    done    = 1'b1;
                    cause   = 2'b10;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign stall_out  = ~done;
    assign dmem_req   = req;
    assign dmem_we    = req & mem_write_in;
    assign dmem_addr  = req ? {alu_result_in[31:2], 2'b00} : 32'h0;
    assign dmem_wdata = req ? st_wdata : 32'h0;
    assign dmem_be    = req ? st_be : 4'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid        <= 1'b0;
            wb_reg_write    <= 1'b0;
            wb_mem_to_reg   <= 1'b0;
            wb_rd           <= 5'd0;
            wb_sel          <= 2'd0;
            wb_pc           <= 32'h0;
            wb_alu_result   <= 32'h0;
            wb_load_data    <= 32'h0;
            mem_fault       <= 1'b0;
            mem_fault_cause <= 2'd0;
        end else if (!done) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            mem_fault    <= 1'b0;
        end else begin
            wb_valid        <= ex_valid;
            wb_reg_write    <= reg_write_in & (cause == 2'b00);
            wb_mem_to_reg   <= mem_to_reg_in;
            wb_rd           <= rd_in;
            wb_sel          <= wb_sel_in;
            wb_pc           <= pc_in;
            wb_alu_result   <= alu_result_in;
            wb_load_data    <= load_ok ? ld_ext : 32'h0;
            mem_fault       <= ex_valid & (cause != 2'b00);
            mem_fault_cause <= cause;
        end
    end

    logic unused_legal;
    assign unused_legal = legal;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a vector table run back-to-back, then timeout,
// late-response and reset-during-access sequences.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] alu_result_in, reg_data2_in, pc_in;
    logic [4:0]  rd_in;
    logic [2:0]  func3_in;
    logic [1:0]  wb_sel_in;
    logic        mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in;
    logic        stall_out, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_reg_write, wb_mem_to_reg;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_sel;
    logic [31:0] wb_pc, wb_alu_result, wb_load_data;
    logic        mem_fault;
    logic [1:0]  mem_fault_cause;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .alu_result_in(alu_result_in),
        .reg_data2_in(reg_data2_in), .rd_in(rd_in), .func3_in(func3_in),
        .wb_sel_in(wb_sel_in), .pc_in(pc_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .reg_write_in(reg_write_in),
        .mem_to_reg_in(mem_to_reg_in), .stall_out(stall_out), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd), .wb_sel(wb_sel), .wb_pc(wb_pc),
        .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data), .mem_fault(mem_fault),
        .mem_fault_cause(mem_fault_cause)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic        rw;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rdi;
        int          gd;
        int          rvc;
        logic        exp_req;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        int          exp_st;
        logic        exp_rw;
        logic        exp_flt;
        logic [1:0]  exp_cause;
        logic [31:0] exp_ld;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered and left at posedge+1; gnt/rvalid pulse in cycles gd/rvc of the access.
    task automatic run_vec(input vec_t v, input logic [31:0] pc);
        int  stalls;
        logic st;
        ex_valid      = 1'b1;
        mem_read_in   = v.rd;
        mem_write_in  = v.wr;
        reg_write_in  = v.rw;
        mem_to_reg_in = v.rd;
        func3_in      = v.f3;
        alu_result_in = v.addr;
        reg_data2_in  = v.wdata;
        dmem_rdata    = v.rdata;
        rd_in         = v.rdi;
        pc_in         = pc;
        wb_sel_in     = 2'b10;
        stalls        = 0;
        for (int c = 0; c < 12; c++) begin
            dmem_gnt    = (c == v.gd);
            dmem_rvalid = (c == v.rvc);
            #2;
            st = stall_out;
            if (c == 0) begin
                chk("stall0", 32'(st), 32'(v.exp_st != 0));
                chk("req", 32'(dmem_req), 32'(v.exp_req));
                chk("we", 32'(dmem_we), 32'(v.exp_req & v.wr));
                chk("be", 32'(dmem_be), 32'(v.exp_be));
                chk("wdata", dmem_wdata, v.exp_wd);
                if (v.exp_req) chk("addr", dmem_addr, {v.addr[31:2], 2'b00});
            end
            @(posedge clk);
            #1;
            if (!st) break;
            stalls++;
            chk("bubble", 32'(wb_valid), 32'd0);
        end
        chk("stalls", 32'(stalls), 32'(v.exp_st));
        chk("wb_valid", 32'(wb_valid), 32'd1);
        chk("wb_reg_write", 32'(wb_reg_write), 32'(v.exp_rw));
        chk("mem_fault", 32'(mem_fault), 32'(v.exp_flt));
        if (v.exp_flt) chk("cause", 32'(mem_fault_cause), 32'(v.exp_cause));
        chk("wb_pc", wb_pc, pc);
        chk("wb_rd", 32'(wb_rd), 32'(v.rdi));
        chk("wb_alu", wb_alu_result, v.addr);
        chk("wb_m2r", 32'(wb_mem_to_reg), 32'(v.rd));
        chk("wb_sel", 32'(wb_sel), 32'd2);
        if (v.rd && !v.exp_flt) chk("load_data", wb_load_data, v.exp_ld);
    endtask

    vec_t tbl[18];
    vec_t v;

    initial begin
        //          rd    wr    rw    f3      addr          wdata         rdata
        //          rdi   gd  rvc  req   be       wd            st  rw    flt   cause  ld
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 3'b000, 32'h00000055, 32'h0, 32'h0,
                    5'd1, 0, 99, 1'b0, 4'b0000, 32'h0, 0, 1'b1, 1'b0, 2'b00, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 3'b000, 32'h00000103, 32'h0, 32'h80AA55CC,
                    5'd2, 0, 2, 1'b1, 4'b1000, 32'h0, 2, 1'b1, 1'b0, 2'b00, 32'hFFFFFF80};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 3'b100, 32'h00000103, 32'h0, 32'h80AA55CC,
                    5'd3, 0, 2, 1'b1, 4'b1000, 32'h0, 2, 1'b1, 1'b0, 2'b00, 32'h00000080};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 3'b001, 32'h00000202, 32'h1234ABCD, 32'h0,
                    5'd4, 0, 99, 1'b1, 4'b1100, 32'hABCDABCD, 0, 1'b0, 1'b0, 2'b00, 32'h0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 3'b000, 32'h00000101, 32'h000000A5, 32'h0,
                    5'd5, 1, 99, 1'b1, 4'b0010, 32'hA5A5A5A5, 1, 1'b0, 1'b0, 2'b00, 32'h0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 3'b010, 32'h00000300, 32'hCAFEF00D, 32'h0,
                    5'd6, 2, 99, 1'b1, 4'b1111, 32'hCAFEF00D, 2, 1'b0, 1'b0, 2'b00, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h00000301, 32'h0, 32'h0,
                    5'd7, 0, 1, 1'b0, 4'b0000, 32'h0, 0, 1'b0, 1'b1, 2'b01, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 3'b001, 32'h00000103, 32'h0, 32'h0,
                    5'd8, 0, 1, 1'b0, 4'b0000, 32'h0, 0, 1'b0, 1'b1, 2'b01, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 3'b001, 32'h00000102, 32'h0, 32'h9ABC1234,
                    5'd9, 1, 2, 1'b1, 4'b1100, 32'h0, 2, 1'b1, 1'b0, 2'b00, 32'hFFFF9ABC};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 3'b101, 32'h00000006, 32'h0, 32'h80011234,
                    5'd10, 1, 3, 1'b1, 4'b1100, 32'h0, 3, 1'b1, 1'b0, 2'b00, 32'h00008001};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h00000008, 32'h0, 32'h01234567,
                    5'd11, 0, 1, 1'b1, 4'b1111, 32'h0, 1, 1'b1, 1'b0, 2'b00, 32'h01234567};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 3'b011, 32'h00000000, 32'h0, 32'h0,
                    5'd12, 0, 1, 1'b0, 4'b0000, 32'h0, 0, 1'b0, 1'b1, 2'b11, 32'h0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 3'b100, 32'h00000000, 32'h11111111, 32'h0,
                    5'd13, 0, 99, 1'b0, 4'b0000, 32'h0, 0, 1'b0, 1'b1, 2'b11, 32'h0};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 3'b010, 32'h00000000, 32'h0, 32'h0,
                    5'd14, 0, 1, 1'b0, 4'b0000, 32'h0, 0, 1'b0, 1'b1, 2'b11, 32'h0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 3'b001, 32'h00000201, 32'h0, 32'h0,
                    5'd15, 0, 99, 1'b0, 4'b0000, 32'h0, 0, 1'b0, 1'b1, 2'b01, 32'h0};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 3'b000, 32'h00000101, 32'h0, 32'h00007F00,
                    5'd16, 0, 1, 1'b1, 4'b0010, 32'h0, 1, 1'b1, 1'b0, 2'b00, 32'h0000007F};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 3'b010, 32'h00000014, 32'h0, 32'h0,
                    5'd17, 99, 99, 1'b1, 4'b1111, 32'h0, 4, 1'b0, 1'b1, 2'b10, 32'h0};
        tbl[17] = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h00000010, 32'h0, 32'h0,
                    5'd18, 0, 99, 1'b1, 4'b1111, 32'h0, 4, 1'b0, 1'b1, 2'b10, 32'h0};

        reset = 1'b1;
        ex_valid = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0; reg_write_in = 1'b0;
        mem_to_reg_in = 1'b0; func3_in = 3'b0; alu_result_in = 32'h0; reg_data2_in = 32'h0;
        rd_in = 5'd0; pc_in = 32'h0; wb_sel_in = 2'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_fault", 32'(mem_fault), 32'd0);
        chk("rst_pc", wb_pc, 32'h0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) run_vec(tbl[i], 32'h1000 + 32'(i) * 4);

        // Response arriving after the timeout must be dropped.
        ex_valid = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h55555555;
        #2;
        chk("late_stall", 32'(stall_out), 32'd0);
        chk("late_req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        chk("late_wb_valid", 32'(wb_valid), 32'd0);
        chk("late_fault", 32'(mem_fault), 32'd0);
        v = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h00000020, 32'h0, 32'h13579BDF,
              5'd19, 1, 2, 1'b1, 4'b1111, 32'h0, 2, 1'b1, 1'b0, 2'b00, 32'h13579BDF};
        run_vec(v, 32'h2000);

        // Reset while waiting for read data.
        ex_valid = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; reg_write_in = 1'b1;
        func3_in = 3'b010; alu_result_in = 32'h0; rd_in = 5'd20; pc_in = 32'h3000;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b0;
        #2;
        chk("pre_rst_stall0", 32'(stall_out), 32'd1);
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        #2;
        chk("pre_rst_stall1", 32'(stall_out), 32'd1);
        reset = 1'b1; ex_valid = 1'b0; mem_read_in = 1'b0; dmem_rvalid = 1'b1;
        dmem_rdata = 32'h99999999;
        #1;
        chk("mid_rst_req", 32'(dmem_req), 32'd0);
        chk("mid_rst_valid", 32'(wb_valid), 32'd0);
        chk("mid_rst_rw", 32'(wb_reg_write), 32'd0);
        chk("mid_rst_pc", wb_pc, 32'h0);
        chk("mid_rst_rd", 32'(wb_rd), 32'd0);
        chk("mid_rst_alu", wb_alu_result, 32'h0);
        chk("mid_rst_ld", wb_load_data, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("post_rst_req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        chk("post_rst_valid", 32'(wb_valid), 32'd0);
        dmem_rvalid = 1'b0;
        v = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h00000000, 32'h0, 32'hDEADBEEF,
              5'd21, 0, 1, 1'b1, 4'b1111, 32'h0, 1, 1'b1, 1'b0, 2'b00, 32'hDEADBEEF};
        run_vec(v, 32'h3004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
